i2s_cfg_sequencer: RTL and testbench

//  Run-time configuration controller for the I2S codec core. Takes config requests (sample resolution,

---
 rtl/i2s_cfg_pkg.sv | 36 +++
 rtl/i2s_frame_tracker.sv | 37 +++
 rtl/i2s_cfg_sequencer.sv | 175 +++++++++++++++++
 tb/tb_i2s_cfg_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_cfg_pkg.sv
// Shared types and constants for the I2S run-time configuration sequencer.
package i2s_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DISABLE,
        APPLY,
        ENABLE,
        SETTLE
    } state_t;

    typedef struct packed {
        logic [5:0] sampleres;
        logic [9:0] clkdiv;
        logic       order;
    } cfg_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int MIN_SAMPLERES  = 8;
    localparam int MIN_BCLKDIV    = 4;
    localparam int DEF_SAMPLERES  = 16;
    localparam int DEF_BCLKDIV    = 21;

    function automatic logic cfg_legal(
        input cfg_t c,
        input int   min_res,
        input int   max_res,
        input int   min_div
    );
        return (c.sampleres >= 6'(min_res)) &&
               (c.sampleres <= 6'(max_res)) &&
               (c.clkdiv >= 10'(min_div));
    endfunction

endpackage

// File: rtl/i2s_frame_tracker.sv
// lrclk edge detector plus a saturating per-edge timeout counter.
module i2s_frame_tracker #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic sysclk,
    input  logic reset,
    input  logic lrclk,
    input  logic clr,
    output logic rise,
    output logic fall,
    output logic timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic          lrclk_q;
    logic [TW-1:0] cnt;

    always_ff @(posedge sysclk) begin
        lrclk_q <= lrclk;
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rise    = lrclk & ~lrclk_q;
    assign fall    = ~lrclk & lrclk_q;
    assign timeout = (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/i2s_cfg_sequencer.sv
// Validates codec config requests and applies them glitch-free across an
// lrclk frame boundary with the output path muted.
module i2s_cfg_sequencer
    import i2s_cfg_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MIN_RES       = MIN_SAMPLERES,
    parameter int MIN_CLKDIV    = MIN_BCLKDIV,
    parameter int DEF_RES       = DEF_SAMPLERES,
    parameter int DEF_CLKDIV    = DEF_BCLKDIV,
    parameter int DIS_CYCLES    = 8,
    parameter int SETTLE_FRAMES = 2,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_sampleres,
    input  logic [9:0] cfg_clkdiv,
    input  logic       cfg_order,
    input  logic       lrclk,
    output logic       enabler,
    output logic [5:0] sampleres,
    output logic [9:0] clkdiv,
    output logic       sampleorder,
    output logic       mute,
    output logic       busy,
    output logic       cfg_err,
    output logic       fault
);

    localparam int DW = $clog2(DIS_CYCLES + 1);
    localparam int FW = $clog2(SETTLE_FRAMES + 1);

    localparam cfg_t DEF_CFG = '{
        sampleres: 6'(DEF_RES),
        clkdiv:    10'(DEF_CLKDIV),
        order:     1'b0
    };

    state_t        state, state_n;
    cfg_t          pend, pend_n;
    cfg_t          cur, cur_n;
    cfg_t          req;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [FW-1:0] frm, frm_n;
    logic          enabler_n, mute_n, ready_n;
    logic          busy_n, err_n, fault_n;
    logic          rise, fall, tmo, clr;
    logic          hs, legal;

    assign req = '{
        sampleres: cfg_sampleres,
        clkdiv:    cfg_clkdiv,
        order:     cfg_order
    };

    assign hs    = cfg_valid & cfg_ready;
    assign legal = cfg_legal(req, MIN_RES, DATA_WIDTH, MIN_CLKDIV);

    i2s_frame_tracker #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_trk (
        .sysclk  (sysclk),
        .reset   (reset),
        .lrclk   (lrclk),
        .clr     (clr),
        .rise    (rise),
        .fall    (fall),
        .timeout (tmo)
    );

    always_comb begin
        state_n = state;
        pend_n  = pend;
        cur_n   = cur;
        dcnt_n  = '0;
        frm_n   = frm;
        err_n   = 1'b0;
        fault_n = fault;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    if (legal) begin
                        pend_n  = req;
                        state_n = DRAIN;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fall || tmo) begin
                    state_n = DISABLE;
                end
            end
            DISABLE: begin
                if (dcnt == DW'(DIS_CYCLES - 1)) begin
                    state_n = APPLY;
                    cur_n   = pend;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            APPLY: begin
                state_n = ENABLE;
            end
            ENABLE: begin
                frm_n   = '0;
                state_n = SETTLE;
            end
            SETTLE: begin
                // a rise on the timeout cycle still counts as a frame
                if (rise) begin
                    if (frm == FW'(SETTLE_FRAMES - 1)) begin
                        state_n = IDLE;
                        fault_n = 1'b0;
                    end else begin
                        frm_n = frm + 1'b1;
                    end
                end else if (tmo) begin
                    state_n = IDLE;
                    fault_n = 1'b1;
                end
            end
            default: begin
                state_n = DISABLE;
            end
        endcase
    end

    always_comb begin
        clr = (state_n != state) ||
              (state == DRAIN && fall) ||
              (state == SETTLE && rise);
        enabler_n = !(state_n inside {DISABLE, APPLY});
        ready_n   = (state_n == IDLE);
        busy_n    = (state_n != IDLE);
        mute_n    = !((state_n == IDLE) && !fault_n);
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state     <= DISABLE;
            pend      <= DEF_CFG;
            cur       <= DEF_CFG;
            dcnt      <= '0;
            frm       <= '0;
            enabler   <= 1'b0;
            mute      <= 1'b1;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            cfg_err   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            cur       <= cur_n;
            dcnt      <= dcnt_n;
            frm       <= frm_n;
            enabler   <= enabler_n;
            mute      <= mute_n;
            cfg_ready <= ready_n;
            busy      <= busy_n;
            cfg_err   <= err_n;
            fault     <= fault_n;
        end
    end

    assign sampleres   = cur.sampleres;
    assign clkdiv      = cur.clkdiv;
    assign sampleorder = cur.order;

endmodule

// File: tb/tb_i2s_cfg_sequencer.sv
// Directed bench for i2s_cfg_sequencer: boot, reject, apply, timeout
// and reset-interrupt sequences against hand-derived cycle counts.
module tb_i2s_cfg_sequencer;

    logic       sysclk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_sampleres;
    logic [9:0] cfg_clkdiv;
    logic       cfg_order;
    logic       lrclk;
    logic       enabler;
    logic [5:0] sampleres;
    logic [9:0] clkdiv;
    logic       sampleorder;
    logic       mute;
    logic       busy;
    logic       cfg_err;
    logic       fault;

    logic lrclk_gen;
    logic lr_hold;
    logic lr_last;
    logic rose;
    logic fell;
    int   n_cmp;
    int   n_err;

    i2s_cfg_sequencer dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_sampleres (cfg_sampleres),
        .cfg_clkdiv    (cfg_clkdiv),
        .cfg_order     (cfg_order),
        .lrclk         (lrclk),
        .enabler       (enabler),
        .sampleres     (sampleres),
        .clkdiv        (clkdiv),
        .sampleorder   (sampleorder),
        .mute          (mute),
        .busy          (busy),
        .cfg_err       (cfg_err),
        .fault         (fault)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // 1344-cycle lrclk period, toggling just after a sysclk edge
    initial begin
        lrclk_gen = 1'b0;
        forever begin
            repeat (672) @(posedge sysclk);
            #1 lrclk_gen = ~lrclk_gen;
        end
    end

    assign lrclk = lr_hold ? 1'b1 : lrclk_gen;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        rose    = lrclk & ~lr_last;
        fell    = ~lrclk & lr_last;
        lr_last = lrclk;
    endtask

    task automatic set_req(input int r, input int d, input int o);
        cfg_sampleres = 6'(r);
        cfg_clkdiv    = 10'(d);
        cfg_order     = 1'(o);
    endtask

    task automatic chk_cfg(input string tag, input int r, input int d, input int o);
        chk({tag, "_res"}, int'(sampleres), r);
        chk({tag, "_div"}, int'(clkdiv), d);
        chk({tag, "_ord"}, int'(sampleorder), o);
    endtask

    task automatic wait_enab(input string tag, input logic lvl, input int bound);
        int cyc;
        cyc = 0;
        while (enabler !== lvl && cyc < bound) begin
            tick();
            cyc++;
        end
        chk(tag, int'(enabler), int'(lvl));
    endtask

    // called on the ENABLE cycle; expects unmute right after the 2nd rise
    task automatic wait_settle(input string tag);
        int   cyc;
        int   nr;
        logic last;
        logic done;
        cyc  = 0;
        nr   = 0;
        last = 1'b0;
        done = 1'b0;
        while (!done && cyc < 4000) begin
            tick();
            cyc++;
            if (cfg_ready) begin
                done = 1'b1;
            end else begin
                last = rose;
                if (rose) nr++;
            end
        end
        chk({tag, "_ready"}, int'(cfg_ready), 1);
        chk({tag, "_rises"}, nr, 2);
        chk({tag, "_rise_edge"}, int'(last), 1);
        chk({tag, "_mute"}, int'(mute), 0);
        chk({tag, "_en"}, int'(enabler), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fault"}, int'(fault), 0);
    endtask

    // reset with a colliding request, then the full boot sequence
    task automatic do_reset(input string tag, input int hold);
        int n;
        reset     = 1'b0;
        cfg_valid = 1'b1;
        set_req(12, 42, 1);
        repeat (hold) tick();
        chk_cfg({tag, "_def"}, 16, 21, 0);
        chk({tag, "_en"}, int'(enabler), 0);
        chk({tag, "_mute"}, int'(mute), 1);
        chk({tag, "_ready"}, int'(cfg_ready), 0);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_err"}, int'(cfg_err), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        reset     = 1'b1;
        cfg_valid = 1'b0;
        n = 0;
        while (!enabler && n < 40) begin
            n++;
            tick();
        end
        // eight DISABLE cycles plus the APPLY cycle
        chk({tag, "_dis_cyc"}, n, 9);
        chk_cfg({tag, "_boot"}, 16, 21, 0);
        wait_settle(tag);
    endtask

    task automatic run_legal(input string tag,
                             input int r, input int d, input int o,
                             input int pr, input int pd, input int po);
        int   cyc;
        int   n;
        logic lastfell;
        set_req(r, d, o);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk({tag, "_mute1"}, int'(mute), 1);
        chk({tag, "_busy1"}, int'(busy), 1);
        chk({tag, "_rdy1"}, int'(cfg_ready), 0);
        chk({tag, "_drain_en"}, int'(enabler), 1);
        cyc = 0;
        lastfell = fell;
        while (enabler && cyc < 1500) begin
            lastfell = fell;
            tick();
            cyc++;
        end
        chk({tag, "_dis"}, int'(enabler), 0);
        chk({tag, "_fall"}, int'(lastfell), 1);
        n = 0;
        while (!enabler && n < 20 &&
               sampleres == 6'(pr) && clkdiv == 10'(pd) &&
               sampleorder == 1'(po)) begin
            n++;
            tick();
        end
        chk({tag, "_dis_cyc"}, n, 8);
        chk_cfg({tag, "_apply"}, r, d, o);
        chk({tag, "_apply_en"}, int'(enabler), 0);
        tick();
        chk({tag, "_reen"}, int'(enabler), 1);
        wait_settle(tag);
    endtask

    logic [5:0] ires [4];
    logic [9:0] idiv [4];

    initial begin
        int i;
        int cyc;
        n_cmp     = 0;
        n_err     = 0;
        lr_hold   = 1'b0;
        lr_last   = 1'b0;
        rose      = 1'b0;
        fell      = 1'b0;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        set_req(0, 0, 0);
        ires = '{6'd24, 6'd7, 6'd17, 6'd16};
        idiv = '{10'd21, 10'd21, 10'd21, 10'd3};

        do_reset("boot", 3);

        for (int k = 0; k < 4; k++) begin
            set_req(int'(ires[k]), int'(idiv[k]), 1);
            cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            chk($sformatf("ill%0d_err", k), int'(cfg_err), 1);
            chk($sformatf("ill%0d_rdy", k), int'(cfg_ready), 1);
            chk($sformatf("ill%0d_mute", k), int'(mute), 0);
            tick();
            chk($sformatf("ill%0d_err0", k), int'(cfg_err), 0);
            chk($sformatf("ill%0d_busy", k), int'(busy), 0);
            chk_cfg($sformatf("ill%0d", k), 16, 21, 0);
        end

        run_legal("cfg12", 12, 42, 1, 16, 21, 0);

        set_req(8, 4, 0);
        cfg_valid = 1'b1;
        tick();
        chk("hold_busy", int'(busy), 1);
        i = 0;
        while (!cfg_ready && i < 6000) begin
            set_req(9 + i % 7, 100 + i % 50, i % 2);
            tick();
            i++;
        end
        chk("hold_ready", int'(cfg_ready), 1);
        chk_cfg("hold", 8, 4, 0);
        set_req(40, 21, 1);
        tick();
        chk("hold_err1", int'(cfg_err), 1);
        chk("hold_rdy1", int'(cfg_ready), 1);
        tick();
        chk("hold_err2", int'(cfg_err), 1);
        cfg_valid = 1'b0;
        tick();
        chk("hold_err0", int'(cfg_err), 0);
        chk_cfg("hold_end", 8, 4, 0);

        lr_hold = 1'b1;
        repeat (3) tick();
        set_req(16, 21, 0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("tmo_busy", int'(busy), 1);
        cyc = 0;
        while (enabler && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("tmo_drain_cyc", cyc, 4096);
        wait_enab("tmo_reen", 1'b1, 20);
        cyc = 0;
        while (!cfg_ready && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("tmo_settle_cyc", cyc, 4097);
        chk("tmo_fault", int'(fault), 1);
        chk("tmo_mute", int'(mute), 1);
        chk("tmo_en", int'(enabler), 1);
        chk("tmo_busy0", int'(busy), 0);
        chk_cfg("tmo", 16, 21, 0);
        lr_hold = 1'b0;
        repeat (2) tick();
        run_legal("recover", 12, 42, 1, 16, 21, 0);

        set_req(10, 8, 0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_enab("rdis_wait", 1'b0, 1500);
        repeat (3) tick();
        do_reset("rst_dis", 1);

        set_req(10, 8, 0);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_enab("rset_wait0", 1'b0, 1500);
        wait_enab("rset_wait1", 1'b1, 20);
        repeat (5) tick();
        chk("rset_busy", int'(busy), 1);
        chk_cfg("rset_pre", 10, 8, 0);
        do_reset("rst_settle", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
